icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, physical fetch address width.
REQ-002 SHALL have parameter IDX_W, default 6, data SRAM set-index width (64 lines).
REQ-003 SHALL have parameter BEAT_W, default 64, memory response beat width (half line).
REQ-004 Ports (name  direction  width  meaning):
  clk  in  1  single clock, all state on rising edge
  rst_aL  in  1  asynchronous active-low reset
  miss_valid  in  1  fetch reports miss
  miss_addr  in  ADDR_W  missing fetch address
  miss_ready  out  1  controller accepts miss
  mem_req_valid  out  1  line request to memory
  mem_req_addr  out  ADDR_W  line-aligned request address
  mem_req_ready  in  1  memory accepts request
  mem_resp_valid  in  1  response beat valid
  mem_resp_data  in  BEAT_W  response beat
  fetch_rd_en  in  1  fetch read request to data SRAM
  fetch_rd_idx  in  IDX_W  fetch read set index
  fetch_stall  out  1  fetch read refused this cycle
  sram_csb  out  1  data SRAM chip select, active low
  sram_web  out  1  data SRAM write enable, active low
  sram_wmask  out  2  per-64-bit-half write mask
  sram_addr  out  IDX_W  data SRAM set index
  sram_din  out  2*BEAT_W  data SRAM write data
  refill_done  out  1  one-cycle pulse, line written
  refill_cnt  out  16  completed refills, saturating

Function
REQ-005 States SHALL be IDLE, REQ, BEAT0, BEAT1, DONE.
REQ-006 miss_ready SHALL equal (state==IDLE); IDLE->REQ on miss_valid&&miss_ready, latching miss_addr.
REQ-007 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL be {latched_addr[ADDR_W-1:4],4'b0}, held stable until mem_req_ready; REQ->BEAT0 on mem_req_valid&&mem_req_ready.
REQ-008 Set index SHALL be latched_addr[IDX_W+3:4].
REQ-009 In BEAT0 with mem_resp_valid, SHALL drive sram_csb=0, sram_web=0, sram_wmask=2'b01, sram_din={beat,beat}, sram_addr=index, same cycle (combinational), then go BEAT1.
REQ-010 In BEAT1 with mem_resp_valid, SHALL write as REQ-009 with sram_wmask=2'b10, then go DONE.
REQ-011 BEAT0/BEAT1 without mem_resp_valid SHALL hold state with sram_csb=1 (waits unbounded).
REQ-012 DONE SHALL last exactly one cycle, assert refill_done=1, increment refill_cnt (saturate at 16'hFFFF), return to IDLE.
REQ-013 Refill write SHALL have priority over fetch: fetch_stall=fetch_rd_en && refill write this cycle.
REQ-014 Otherwise fetch_rd_en SHALL pass through: sram_csb=0, sram_web=1, sram_wmask=2'b00, sram_addr=fetch_rd_idx; fetch_stall=0.
REQ-015 Fetch read to the index being refilled (state BEAT0/BEAT1, idx match) SHALL be stalled even without a write that cycle.
REQ-016 No access: sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0.
REQ-017 mem_resp_valid in IDLE, REQ or DONE SHALL be ignored (no write, no state change).
REQ-018 miss_valid while not IDLE SHALL not be accepted; requester holds it.

Reset
REQ-019 rst_aL low SHALL asynchronously force IDLE, latched address 0, refill_cnt 0.
REQ-020 During/after reset: mem_req_valid=0, refill_done=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, fetch_stall=0, miss_ready=1.
REQ-021 Reset mid-refill SHALL abandon the line (partial half may remain in SRAM); later beats ignored per REQ-017.

Structure
REQ-022 icache_pkg SHALL hold IDX_W, BEAT_W, LINE_W=128, offset width 4, refill state enum.
REQ-023 Single module; no sub-module.

Verification
REQ-024 miss_addr=32'h0000_1234, ready immediate, beats 64'hA, 64'hB -> req addr 32'h0000_1230, writes idx 6'h23 mask 01 din {A,A}, then mask 10 din {B,B}, refill_done one cycle, refill_cnt=1.
REQ-025 mem_req_ready low 5 cycles -> mem_req_valid/addr stable 5 cycles, no SRAM write.
REQ-026 fetch_rd_en idx 6'h05 during BEAT0 write to idx 6'h23 -> fetch_stall=1; next idle cycle read passes, stall=0.
REQ-027 fetch_rd_en idx 6'h23 while in BEAT1 awaiting beat -> fetch_stall=1.
REQ-028 rst_aL low after beat0 -> IDLE immediately, outputs per REQ-020; later beat produces no write.
REQ-029 refill_cnt preset path: 65536 refills -> refill_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache line refill controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package icache_pkg;

   localparam int IDX_W  = 6;     // data SRAM set index (64 lines)
   localparam int BEAT_W = 64;    // memory response beat, half a line
   localparam int LINE_W = 128;   // full cache line
   localparam int OFF_W  = 4;     // byte offset within a 16-byte line
   localparam int CNT_W  = 16;    // completed-refill counter width

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      BEAT0 = 3'd2,
      BEAT1 = 3'd3,
      DONE  = 3'd4
   } refill_state_t;

endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache refill controller: one outstanding miss, fetches a 128-bit line as two 64-bit
//    beats and writes each half into the data SRAM, arbitrating against fetch reads.
// Latency: memory request one cycle after miss accept; each beat is written to SRAM in the
//    same cycle it arrives; refill_done pulses one cycle after the second beat.
// Backpressure: miss_ready low while a refill is in flight; request held until
//    mem_req_ready; beats may arrive with unbounded gaps; fetch reads stalled on conflict.
//
// Ports:
//   clk, rst_aL                  clock, asynchronous active-low reset
//   miss_valid/miss_addr/miss_ready        miss handshake from fetch
//   mem_req_valid/mem_req_addr/mem_req_ready  line-aligned request to memory
//   mem_resp_valid/mem_resp_data           response beats (no ready; always accepted)
//   fetch_rd_en/fetch_rd_idx/fetch_stall   fetch read port into data SRAM
//   sram_csb/sram_web/sram_wmask/sram_addr/sram_din  data SRAM (active-low strobes)
//   refill_done, refill_cnt                completion pulse and saturating count
module icache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = icache_pkg::IDX_W,
   parameter int BEAT_W = icache_pkg::BEAT_W
) (
   input  logic                clk,
   input  logic                rst_aL,
   input  logic                miss_valid,
   input  logic [ADDR_W-1:0]   miss_addr,
   output logic                miss_ready,
   output logic                mem_req_valid,
   output logic [ADDR_W-1:0]   mem_req_addr,
   input  logic                mem_req_ready,
   input  logic                mem_resp_valid,
   input  logic [BEAT_W-1:0]   mem_resp_data,
   input  logic                fetch_rd_en,
   input  logic [IDX_W-1:0]    fetch_rd_idx,
   output logic                fetch_stall,
   output logic                sram_csb,
   output logic                sram_web,
   output logic [1:0]          sram_wmask,
   output logic [IDX_W-1:0]    sram_addr,
   output logic [2*BEAT_W-1:0] sram_din,
   output logic                refill_done,
   output logic [15:0]         refill_cnt
);

   import icache_pkg::*;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

   refill_state_t     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  refill_cnt_q;

   logic [IDX_W-1:0]  line_idx;
   logic              in_beat;
   logic              refill_wr;
   logic              idx_hit;

   assign line_idx  = addr_q[IDX_W+OFF_W-1:OFF_W];
   assign in_beat   = (state_q == BEAT0) || (state_q == BEAT1);
   assign refill_wr = in_beat && mem_resp_valid;
   // A read of the line being refilled would return a half-written line, so it is held off
   // for the whole beat window, not just the write cycles.
   assign idx_hit   = in_beat && (fetch_rd_idx == line_idx);

   assign miss_ready    = (state_q == IDLE);
   assign mem_req_valid = (state_q == REQ);
   assign mem_req_addr  = addr_q & ALIGN_MASK;
   assign refill_done   = (state_q == DONE);
   assign refill_cnt    = refill_cnt_q;

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         refill_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_valid) begin
                  addr_q  <= miss_addr;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) state_q <= BEAT0;
            end
            BEAT0: begin
               if (mem_resp_valid) state_q <= BEAT1;
            end
            BEAT1: begin
               if (mem_resp_valid) state_q <= DONE;
            end
            DONE: begin
               if (refill_cnt_q != {CNT_W{1'b1}}) refill_cnt_q <= refill_cnt_q + CNT_W'(1);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // SRAM port arbitration: refill write wins, then fetch read, else idle.
   always_comb begin
      sram_csb    = 1'b1;
      sram_web    = 1'b1;
      sram_wmask  = 2'b00;
      sram_addr   = '0;
      sram_din    = '0;
      fetch_stall = 1'b0;
      if (refill_wr) begin
         sram_csb    = 1'b0;
         sram_web    = 1'b0;
         sram_wmask  = (state_q == BEAT0) ? 2'b01 : 2'b10;
         sram_addr   = line_idx;
         sram_din    = {mem_resp_data, mem_resp_data};
         fetch_stall = fetch_rd_en;
      end else if (fetch_rd_en) begin
         if (idx_hit) begin
            fetch_stall = 1'b1;
         end else begin
            sram_csb  = 1'b0;
            sram_addr = fetch_rd_idx;
         end
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
// Expected values are hand-derived constants.
module tb_icache_refill_ctrl;

   logic         clk = 1'b0;
   logic         rst_aL;
   logic         miss_valid;
   logic [31:0]  miss_addr;
   logic         miss_ready;
   logic         mem_req_valid;
   logic [31:0]  mem_req_addr;
   logic         mem_req_ready;
   logic         mem_resp_valid;
   logic [63:0]  mem_resp_data;
   logic         fetch_rd_en;
   logic [5:0]   fetch_rd_idx;
   logic         fetch_stall;
   logic         sram_csb;
   logic         sram_web;
   logic [1:0]   sram_wmask;
   logic [5:0]   sram_addr;
   logic [127:0] sram_din;
   logic         refill_done;
   logic [15:0]  refill_cnt;

   int errors = 0;
   int checks = 0;

   icache_refill_ctrl dut (
      .clk            (clk),
      .rst_aL         (rst_aL),
      .miss_valid     (miss_valid),
      .miss_addr      (miss_addr),
      .miss_ready     (miss_ready),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .fetch_rd_en    (fetch_rd_en),
      .fetch_rd_idx   (fetch_rd_idx),
      .fetch_stall    (fetch_stall),
      .sram_csb       (sram_csb),
      .sram_web       (sram_web),
      .sram_wmask     (sram_wmask),
      .sram_addr      (sram_addr),
      .sram_din       (sram_din),
      .refill_done    (refill_done),
      .refill_cnt     (refill_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outputs that must hold whenever the controller is idle with no fetch read.
   task automatic check_quiet(input string tag);
      check({tag, ".miss_ready"},    miss_ready,    1'b1);
      check({tag, ".mem_req_valid"}, mem_req_valid, 1'b0);
      check({tag, ".refill_done"},   refill_done,   1'b0);
      check({tag, ".sram_csb"},      sram_csb,      1'b1);
      check({tag, ".sram_web"},      sram_web,      1'b1);
      check({tag, ".sram_wmask"},    sram_wmask,    2'b00);
      check({tag, ".sram_addr"},     sram_addr,     6'h00);
      check({tag, ".sram_din"},      sram_din,      128'h0);
      check({tag, ".fetch_stall"},   fetch_stall,   1'b0);
   endtask

   // Full refill with immediate ready and back-to-back beats; checks completion and count.
   task automatic do_refill(input logic [31:0] addr, input logic [15:0] exp_cnt);
      miss_valid = 1'b1; miss_addr = addr; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
      tick();                                   // REQ
      miss_valid = 1'b0;
      tick();                                   // BEAT0
      mem_resp_valid = 1'b1; mem_resp_data = 64'h5;
      tick();                                   // BEAT1
      tick();                                   // DONE
      mem_resp_valid = 1'b0;
      #1 check("sat.done", refill_done, 1'b1);
      tick();                                   // IDLE
      #1 check("sat.cnt", refill_cnt, exp_cnt);
   endtask

   initial begin
      rst_aL = 1'b0;
      miss_valid = 1'b0; miss_addr = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      fetch_rd_en = 1'b0; fetch_rd_idx = '0;

      // Reset state
      #3;
      check_quiet("rst");
      check("rst.cnt", refill_cnt, 16'h0);
      #9 rst_aL = 1'b1;
      tick();

      // Basic refill of 0x1234: line 0x1230, index 0x23
      miss_valid = 1'b1; miss_addr = 32'h0000_1234; mem_req_ready = 1'b1;
      #1 check("t1.miss_ready", miss_ready, 1'b1);
      tick();                                   // REQ
      miss_valid = 1'b0;
      #1;
      check("t1.req_valid", mem_req_valid, 1'b1);
      check("t1.req_addr", mem_req_addr, 32'h0000_1230);
      check("t1.miss_ready_busy", miss_ready, 1'b0);
      tick();                                   // BEAT0
      mem_resp_valid = 1'b1; mem_resp_data = 64'hA;
      fetch_rd_en = 1'b1; fetch_rd_idx = 6'h05;
      #1;
      check("t1.b0.csb", sram_csb, 1'b0);
      check("t1.b0.web", sram_web, 1'b0);
      check("t1.b0.mask", sram_wmask, 2'b01);
      check("t1.b0.addr", sram_addr, 6'h23);
      check("t1.b0.din", sram_din, {64'hA, 64'hA});
      check("t1.b0.stall", fetch_stall, 1'b1);
      tick();                                   // BEAT1
      mem_resp_data = 64'hB; fetch_rd_en = 1'b0;
      #1;
      check("t1.b1.csb", sram_csb, 1'b0);
      check("t1.b1.mask", sram_wmask, 2'b10);
      check("t1.b1.addr", sram_addr, 6'h23);
      check("t1.b1.din", sram_din, {64'hB, 64'hB});
      tick();                                   // DONE
      mem_resp_valid = 1'b0;
      #1;
      check("t1.done", refill_done, 1'b1);
      check("t1.done_cnt", refill_cnt, 16'h0);
      tick();                                   // IDLE
      fetch_rd_en = 1'b1; fetch_rd_idx = 6'h05;
      #1;
      check("t1.done_pulse", refill_done, 1'b0);
      check("t1.cnt", refill_cnt, 16'h1);
      check("t1.rd.stall", fetch_stall, 1'b0);
      check("t1.rd.csb", sram_csb, 1'b0);
      check("t1.rd.web", sram_web, 1'b1);
      check("t1.rd.mask", sram_wmask, 2'b00);
      check("t1.rd.addr", sram_addr, 6'h05);
      fetch_rd_en = 1'b0;
      #1 check_quiet("t1.idle");

      // Request backpressure, ignored beats/misses, stall on refilling index
      tick();
      miss_valid = 1'b1; miss_addr = 32'h0000_ABC8; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD;
      #1 check("t2.idle_beat_csb", sram_csb, 1'b1);
      tick();                                   // REQ
      miss_valid = 1'b1; miss_addr = 32'h0000_0FF0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t2.hold.valid", mem_req_valid, 1'b1);
         check("t2.hold.addr", mem_req_addr, 32'h0000_ABC0);
         check("t2.hold.csb", sram_csb, 1'b1);
         check("t2.hold.miss_ready", miss_ready, 1'b0);
         tick();
      end
      miss_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
      #1 check("t2.still_req", mem_req_valid, 1'b1);
      tick();                                   // BEAT0
      mem_resp_valid = 1'b1; mem_resp_data = 64'h1111;
      #1;
      check("t2.b0.addr", sram_addr, 6'h3C);
      check("t2.b0.mask", sram_wmask, 2'b01);
      tick();                                   // BEAT1, waiting
      mem_resp_valid = 1'b0; fetch_rd_en = 1'b1; fetch_rd_idx = 6'h3C;
      #1;
      check("t2.hit.stall", fetch_stall, 1'b1);
      check("t2.hit.csb", sram_csb, 1'b1);
      tick();                                   // still BEAT1
      fetch_rd_idx = 6'h07;
      #1;
      check("t2.miss.stall", fetch_stall, 1'b0);
      check("t2.miss.csb", sram_csb, 1'b0);
      check("t2.miss.addr", sram_addr, 6'h07);
      tick();
      fetch_rd_en = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h2222;
      #1;
      check("t2.b1.mask", sram_wmask, 2'b10);
      check("t2.b1.din", sram_din, {64'h2222, 64'h2222});
      tick();                                   // DONE
      mem_resp_valid = 1'b0;
      #1 check("t2.done", refill_done, 1'b1);
      tick();
      #1 check("t2.cnt", refill_cnt, 16'h2);

      // Reset in the middle of a refill
      miss_valid = 1'b1; miss_addr = 32'h0000_0050; mem_req_ready = 1'b1;
      tick();                                   // REQ
      miss_valid = 1'b0;
      tick();                                   // BEAT0
      mem_resp_valid = 1'b1; mem_resp_data = 64'h3333;
      #1 check("t3.b0.csb", sram_csb, 1'b0);
      tick();                                   // BEAT1
      rst_aL = 1'b0;
      #1;
      check_quiet("t3.rst");
      check("t3.rst.cnt", refill_cnt, 16'h0);
      tick();
      rst_aL = 1'b1;
      tick();
      #1;
      check("t3.late_beat_csb", sram_csb, 1'b1);
      check("t3.late_req_valid", mem_req_valid, 1'b0);
      check("t3.late_done", refill_done, 1'b0);
      mem_resp_valid = 1'b0;
      tick();

      // Counter saturation, starting from a preset near the top
      force dut.refill_cnt_q = 16'hFFFD;
      #1 release dut.refill_cnt_q;
      #1 check("sat.preset", refill_cnt, 16'hFFFD);
      tick();
      do_refill(32'h0000_0100, 16'hFFFE);
      do_refill(32'h0000_0200, 16'hFFFF);
      do_refill(32'h0000_0300, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
